wrr_lock_arbiter: RTL and testbench
===================================

Name: wrr_lock_arbiter

Overview:
- Parametrised weighted round-robin arbiter with packet locking, for N requesters sharing one downstream port.
- Grant is registered, one-hot and held for a whole multi-beat packet.
- A requester may win up to its programmed weight of consecutive packets before priority rotates past it.
- Successor to the single-cycle mask/unmask round-robin arbiter. It adds weights, lock-until-last and a downstream accept handshake.

Parameters:
- N, 4, number of requesters (N >= 2).
- WW, 4, width of each per-requester weight field.
- IW, $clog2(N), width of the granted-index output (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester request; must stay high until the requester's last beat is accepted.
- req_last  in  N  per-requester "current beat is last of packet".
- weight  in  N*WW  packed weights; requester i occupies bits [i*WW +: WW]; quasi-static.
- accept  in  1  downstream takes the granted beat this cycle.
- grant  out  N  registered one-hot grant.
- grant_valid  out  1  equals |grant.
- grant_idx  out  IW  binary index of the grant bit; 0 when grant_valid is low.
- grant_last  out  1  req_last of the owner, gated by grant_valid.

Behaviour:
- Reset (async, rst_n low):
  - grant=0, grant_valid=0, grant_idx=0.
  - Pointer = one-hot bit 0 (requester 0 highest priority); credit=0; FSM=IDLE.
- State: pointer (priority start), owner index, credit counter (WW bits), FSM {IDLE, LOCKED}.
- Arbitration (combinational):
  - masked = req & thermometer mask (bits >= pointer).
  - Pick the lowest set bit of masked; if masked==0, pick the lowest set bit of req.
  - The result is always one-hot or zero.
- IDLE:
  - Any req high at cycle t -> grant registered at t+1 to the arbitrated winner; FSM -> LOCKED.
  - credit loaded with max(weight[winner],1)-1.
- LOCKED: grant held constant while the owner's req is high, regardless of other requests.
- Beat completion = accept & req[owner].
- Packet end = beat completion & req_last[owner] at cycle t.
  - If credit>0 and req[owner] is high at t: owner keeps the grant at t+1 with no bubble; credit decrements. req is sampled in the same cycle as the last beat, so a requester with a back-to-back packet holds req high.
  - Else: pointer <= one-hot(owner+1), wrapping N-1 -> 0.
    - A new arbitration over the other requesters runs in the same cycle using the updated mask. The owner is excluded for this one decision.
    - If any other req is high, the new owner is granted at t+1 (no bubble) and credit is reloaded from its weight.
    - If none is high but the old owner's req is high, the old owner wins with fresh credit.
    - If no req is high, the grant drops at t+1 and FSM -> IDLE.
- Abort: owner drops req while LOCKED without a completed last beat -> treated as packet end with credit forced to 0 (pointer advances).
- accept while grant_valid=0 is ignored.
- Weight 0 behaves as weight 1.
- Weight changes take effect only on the next credit load.
- Weights are N*WW bits total; credit never underflows (saturates at 0).
- Invariants, checked by assertions:
  - $onehot0(grant).
  - grant_idx consistent with grant.
  - Grant never changes mid-packet unless the owner aborts.

Decomposition:
- Package wrr_arb_pkg: FSM state enum {IDLE, LOCKED}; function onehot_to_idx; function thermo_mask(ptr).
- Sub-module prio_pick #(N): lowest-set-bit one-hot picker. It is instantiated twice, for the masked and unmasked request vectors.

Test Plan:
- Reset with req=4'b1111, weights all 1, single-beat packets, accept=1 -> grants 0,1,2,3,0 on consecutive cycles starting 1 cycle after req, no bubbles.
- weight={4,1,1,1} (req0 weight 4), all single-beat, all req held -> sequence 0,0,0,0,1,2,3,0,0,0,0.
- req=4'b0011, req0 sends a 3-beat packet (last on beat 3), accept toggles 1,0,1,1 -> grant stays 4'b0001 for 4 cycles, moves to 4'b0010 the cycle after the last accept.
- req1 alone holds the grant, its weight is 2, other reqs 0 -> it keeps the grant for 2+ packets with fresh credit; grant never drops while req1 stays high.
- Owner 2 drops req mid-packet (no last) while req3 is high -> grant 4'b1000 next cycle, pointer=bit 3.
- Assert rst_n low while LOCKED mid-packet -> grant=0, grant_idx=0 immediately. After release, req=4'b1010 -> grant 4'b0010 first (pointer back to 0).

Source files
------------

// File: rtl/wrr_lock_arbiter_pkg.sv
// wrr_lock_arbiter_pkg: shared FSM state type and one-hot/mask helpers for the arbiter
package wrr_arb_pkg;
  localparam int MAXN = 32;
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic int onehot_to_idx(input logic [MAXN-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAXN; i++) if (oh[i]) r |= i;
    return r;
  endfunction
  function automatic logic [MAXN-1:0] thermo_mask(input logic [MAXN-1:0] ptr);
    return ~(ptr - MAXN'(1));
  endfunction
endpackage

// File: rtl/wrr_lock_arbiter_if.sv
// wrr_lock_arbiter_if: requester/arbiter bundle for the weighted round-robin lock arbiter
interface wrr_lock_arbiter_if #(parameter int N = 4, parameter int WW = 4);
  localparam int IW = $clog2(N);
  logic [N-1:0] req;
  logic [N-1:0] req_last;
  logic [N*WW-1:0] weight;
  logic accept;
  logic [N-1:0] grant;
  logic grant_valid;
  logic [IW-1:0] grant_idx;
  logic grant_last;
  modport master (output req, req_last, weight, accept, input grant, grant_valid, grant_idx, grant_last);
  modport slave (input req, req_last, weight, accept, output grant, grant_valid, grant_idx, grant_last);
endinterface

// File: rtl/wrr_lock_arbiter_prio_pick.sv
// prio_pick: isolates the lowest set bit of a request vector
module prio_pick #(parameter int N = 4) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);
  assign out = in & (~in + N'(1));
endmodule

// File: rtl/wrr_lock_arbiter.sv
// wrr_lock_arbiter: weighted round-robin arbiter holding the grant for whole packets
module wrr_lock_arbiter import wrr_arb_pkg::*; #(
  parameter int N = 4,
  parameter int WW = 4,
  localparam int IW = $clog2(N)
) (
  input logic clk,
  input logic rst_n,
  wrr_lock_arbiter_if.slave bus
);
  logic [N-1:0] grant_q, grant_d, ptr_q, ptr_d, ptr_nx, others, cand, base, masked, pick_m, pick_u, win;
  logic [WW-1:0] credit_q, credit_d, w_win, load;
  logic [IW-1:0] win_idx;
  logic [MAXN-1:0] mask_x;
  logic own_req, pend;
  state_t state_q, state_d;

  // Arbitration inputs: after a packet end the owner is excluded unless nobody else is asking
  always_comb begin
    ptr_nx = {grant_q[N-2:0], grant_q[N-1]};
    others = bus.req & ~grant_q;
    cand = state_q == IDLE ? bus.req : (|others ? others : bus.req);
    base = state_q == IDLE ? ptr_q : ptr_nx;
    mask_x = thermo_mask(MAXN'(base));
    masked = cand & mask_x[N-1:0];
    win = |masked ? pick_m : pick_u;
    win_idx = IW'(onehot_to_idx(MAXN'(win)));
    w_win = bus.weight[win_idx*WW +: WW];
    load = w_win == '0 ? '0 : w_win - WW'(1);
    own_req = |(grant_q & bus.req);
    pend = bus.accept & own_req & |(grant_q & bus.req_last);
  end

  prio_pick #(.N(N)) u_pick_m (.in(masked), .out(pick_m));
  prio_pick #(.N(N)) u_pick_u (.in(cand), .out(pick_u));

  // Next state: lock on win, spend credit on back-to-back packets, rotate on end or abort
  always_comb begin
    grant_d = grant_q;
    ptr_d = ptr_q;
    credit_d = credit_q;
    state_d = state_q;
    if (state_q == IDLE) begin
      if (|win) begin
        grant_d = win;
        credit_d = load;
        state_d = LOCKED;
      end
    end else if (pend && credit_q != '0) begin
      credit_d = credit_q - WW'(1);
    end else if (pend || !own_req) begin
      ptr_d = ptr_nx;
      grant_d = win;
      credit_d = |win ? load : '0;
      state_d = |win ? LOCKED : IDLE;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q <= N'(1);
      credit_q <= '0;
      state_q <= IDLE;
    end else begin
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      credit_q <= credit_d;
      state_q <= state_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx = IW'(onehot_to_idx(MAXN'(grant_q)));
  assign bus.grant_last = |(grant_q & bus.req_last);

  a_onehot: assert property (@(posedge clk) $onehot0(grant_q));
  a_idx: assert property (@(posedge clk) (grant_q[bus.grant_idx] == bus.grant_valid) && (bus.grant_valid || bus.grant_idx == '0));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n) (state_q == LOCKED && own_req && !pend) |=> grant_q == $past(grant_q));
endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// tb_wrr_lock_arbiter: table-driven directed check of the weighted round-robin lock arbiter
module tb_wrr_lock_arbiter;
  typedef struct packed {
    logic rst;
    logic [3:0] req;
    logic [3:0] last;
    logic acc;
    logic [15:0] w;
    logic [3:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  vec_t tv[$];

  wrr_lock_arbiter_if #(.N(4), .WW(4)) bus();
  wrr_lock_arbiter #(.N(4), .WW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [1:0] idx4(input logic [3:0] g);
    return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_grant(input string name, input logic [3:0] exp, input logic [3:0] last);
    check({name, ".grant"}, 32'(bus.grant), 32'(exp));
    check({name, ".valid"}, 32'(bus.grant_valid), 32'(|exp));
    check({name, ".idx"}, 32'(bus.grant_idx), 32'(idx4(exp)));
    check({name, ".last"}, 32'(bus.grant_last), 32'(|(exp & last)));
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.req_last = '0;
    bus.accept = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] l, input logic a, input logic [15:0] w, input logic [3:0] e);
    vec_t v;
    v = {r, q, l, a, w, e};
    tv.push_back(v);
  endtask

  initial begin
    bus.req = '0;
    bus.req_last = '0;
    bus.accept = 1'b0;
    bus.weight = 16'h1111;
    #3;
    check_grant("reset", 4'b0000, 4'b0000);
    // plain round robin, weights 1
    add(1, 4'hF, 4'hF, 1, 16'h1111, 4'b0001);
    add(0, 4'hF, 4'hF, 1, 16'h1111, 4'b0010);
    add(0, 4'hF, 4'hF, 1, 16'h1111, 4'b0100);
    add(0, 4'hF, 4'hF, 1, 16'h1111, 4'b1000);
    add(0, 4'hF, 4'hF, 1, 16'h1111, 4'b0001);
    add(0, 4'h0, 4'h0, 1, 16'h1111, 4'b0000);
    // req0 weight 4
    add(1, 4'hF, 4'hF, 1, 16'h1114, 4'b0001);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0001);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0001);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0001);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0010);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0100);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b1000);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0001);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0001);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0001);
    add(0, 4'hF, 4'hF, 1, 16'h1114, 4'b0001);
    // 3-beat packet with accept stalls
    add(1, 4'h3, 4'h0, 0, 16'h1111, 4'b0001);
    add(0, 4'h3, 4'h0, 1, 16'h1111, 4'b0001);
    add(0, 4'h3, 4'h0, 0, 16'h1111, 4'b0001);
    add(0, 4'h3, 4'h0, 1, 16'h1111, 4'b0001);
    add(0, 4'h3, 4'h1, 1, 16'h1111, 4'b0010);
    add(0, 4'h2, 4'h0, 0, 16'h1111, 4'b0010);
    // lone requester with weight 2 keeps the grant
    add(1, 4'h2, 4'h2, 1, 16'h1121, 4'b0010);
    add(0, 4'h2, 4'h2, 1, 16'h1121, 4'b0010);
    add(0, 4'h2, 4'h2, 1, 16'h1121, 4'b0010);
    add(0, 4'h2, 4'h2, 1, 16'h1121, 4'b0010);
    add(0, 4'h2, 4'h2, 1, 16'h1121, 4'b0010);
    // owner 2 aborts, req3 takes over, then wrap to 0
    add(1, 4'h4, 4'h0, 0, 16'h1111, 4'b0100);
    add(0, 4'hC, 4'h0, 1, 16'h1111, 4'b0100);
    add(0, 4'h8, 4'h0, 1, 16'h1111, 4'b1000);
    add(0, 4'h8, 4'h0, 0, 16'h1111, 4'b1000);
    add(0, 4'hB, 4'h8, 1, 16'h1111, 4'b0001);
    // weight 0 acts as weight 1
    add(1, 4'h3, 4'h3, 1, 16'h1110, 4'b0001);
    add(0, 4'h3, 4'h3, 1, 16'h1110, 4'b0010);
    add(0, 4'h3, 4'h3, 1, 16'h1110, 4'b0001);
    add(0, 4'h3, 4'h3, 1, 16'h1110, 4'b0010);
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      bus.req = tv[i].req;
      bus.req_last = tv[i].last;
      bus.accept = tv[i].acc;
      bus.weight = tv[i].w;
      @(posedge clk);
      #1 check_grant($sformatf("vec%0d", i), tv[i].exp, tv[i].last);
    end
    // asynchronous reset while locked mid-packet, then pointer back at 0
    do_reset();
    bus.weight = 16'h1111;
    bus.req = 4'h3;
    @(posedge clk);
    #1 check_grant("pre_rst", 4'b0001, 4'b0000);
    #3 rst_n = 1'b0;
    #1 check_grant("async_rst", 4'b0000, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.req = 4'hA;
    @(posedge clk);
    #1 check_grant("post_rst", 4'b0010, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
